// File: rtl/pic_match_collector.sv
// -----------------------------------------------------------------------------
// pic_match_collector
//
// Drains the 16 per-PIC match FIFOs behind the 4x4 parallel index comparison
// array. A round-robin arbiter picks one non-empty lane per cycle. The popped
// word arrives one cycle later and is parked in a 2-entry, order-preserving
// buffer. The buffer head drives a valid/ready stream to the MAC stage.
// Completion is signalled once a flush has been seen and everything has
// drained.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle pulse, IDLE -> RUN
//   flush        one-cycle pulse, RUN -> DRAIN
//   fifo_data    per-lane read data, valid the cycle after fifo_rd
//   fifo_empty   per-lane empty flags
//   fifo_rd      one-hot (or zero) pop strobe
//   out_valid / out_ready / out_a_idx / out_b_idx / out_lane
//                pair stream; lane = {A lane, B lane}
//   busy         high in RUN and DRAIN
//   done         one-cycle completion pulse
//   match_count  accepted-pair counter
//
// Optional feature macro: PIC_MATCH_COUNT_EN. When it is defined, match_count
// counts accepted pairs and saturates at 0xFFFF. When it is not defined,
// match_count is tied to zero.
// -----------------------------------------------------------------------------
module pic_match_collector #(
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 32,
    parameter int LANE_W    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              flush,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]  fifo_data,
    input  logic [NUM_LANES-1:0]              fifo_empty,
    output logic [NUM_LANES-1:0]              fifo_rd,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [15:0]                       out_a_idx,
    output logic [15:0]                       out_b_idx,
    output logic [LANE_W-1:0]                 out_lane,
    output logic                              busy,
    output logic                              done,
    output logic [15:0]                       match_count
);

    localparam int ENT_W = LANE_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   ptr_q, ptr_d;
    logic                infl_q;
    logic [LANE_W-1:0]   infl_lane_q;
    logic [1:0]          cnt_q, cnt_d;
    logic [ENT_W-1:0]    slot0_q, slot0_d, slot1_q, slot1_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic                gnt_found_s;
    logic [LANE_W-1:0]   gnt_lane_s;
    logic [LANE_W-1:0]   scan_idx_s;
    logic                accept_s;
    logic [2:0]          pend_s;
    logic                pop_s;
    logic [ENT_W-1:0]    cap_ent_s;

    assign out_valid = (cnt_q != 2'd0);
    assign accept_s  = out_valid & out_ready;
    assign out_a_idx = slot0_q[31:16];
    assign out_b_idx = slot0_q[15:0];
    assign out_lane  = slot0_q[ENT_W-1:DATA_W];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cap_ent_s = {infl_lane_q, fifo_data[infl_lane_q]};

    // Count a pair that leaves this cycle as already gone. This keeps one
    // pair per cycle flowing while never exceeding two pending pairs.
    assign pend_s = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, accept_s};

    // Round-robin search: first non-empty lane at or after the pointer.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_lane_s  = '0;
        scan_idx_s  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            scan_idx_s = ptr_q + LANE_W'(i);
            if (!gnt_found_s && !fifo_empty[scan_idx_s]) begin
                gnt_found_s = 1'b1;
                gnt_lane_s  = scan_idx_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_RUN : S_IDLE;
            S_RUN:   state_d = flush ? S_DRAIN : S_RUN;
            S_DRAIN: begin
                if ((&fifo_empty) && !infl_q && (cnt_q == 2'd0)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the pop strobe and the next values of the busy/done flags.
    always_comb begin
        fifo_rd = '0;
        pop_s   = 1'b0;
        if (((state_q == S_RUN) || (state_q == S_DRAIN)) && gnt_found_s && (pend_s < 3'd2)) begin
            pop_s               = 1'b1;
            fifo_rd[gnt_lane_s] = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Pointer advance and buffer update. The buffer is ordered: slot0 is the
    // head that is presented on the output.
    always_comb begin
        ptr_d   = pop_s ? (gnt_lane_s + {{(LANE_W-1){1'b0}}, 1'b1}) : ptr_q;
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({infl_q, accept_s})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    slot0_d = cap_ent_s;
                end else begin
                    slot1_d = cap_ent_s;
                end
            end
            2'b01: begin
                cnt_d   = cnt_q - 2'd1;
                slot0_d = slot1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = cap_ent_s;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = cap_ent_s;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers: pointer, in-flight tracking, buffer, and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            infl_q      <= 1'b0;
            infl_lane_q <= '0;
            cnt_q       <= 2'd0;
            slot0_q     <= '0;
            slot1_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            infl_q      <= pop_s;
            infl_lane_q <= gnt_lane_s;
            cnt_q       <= cnt_d;
            slot0_q     <= slot0_d;
            slot1_q     <= slot1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef PIC_MATCH_COUNT_EN
    logic [15:0] mcnt_q, mcnt_d;

    // Accepted-pair counter: cleared when a run starts, saturating.
    always_comb begin
        if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
            mcnt_d = 16'h0000;
        end else if (accept_s && (mcnt_q != 16'hFFFF)) begin
            mcnt_d = mcnt_q + 16'h0001;
        end else begin
            mcnt_d = mcnt_q;
        end
    end

    // Accepted-pair counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt_q <= 16'h0000;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign match_count = mcnt_q;
`else
    assign match_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pic_match_collector.sv
// -----------------------------------------------------------------------------
// Self-checking bench for pic_match_collector.
//
// The bench models the upstream FIFOs as queues. It holds its own view of the
// collector: the run state, the round-robin pointer, and the list of pairs
// that have been popped but not yet accepted. Each cycle it predicts the pop
// strobe, the output valid and data, busy, done and match_count, and compares
// them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pic_match_collector;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic [15:0][31:0]  fifo_data = '0;
    logic [15:0]        fifo_empty = 16'hFFFF;
    logic [15:0]        fifo_rd;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [15:0]        out_a_idx, out_b_idx;
    logic [3:0]         out_lane;
    logic               busy, done;
    logic [15:0]        match_count;

    pic_match_collector dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a_idx(out_a_idx), .out_b_idx(out_b_idx), .out_lane(out_lane),
        .busy(busy), .done(done), .match_count(match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [31:0] word;
        int          cyc;
    } pend_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  lq [16][$];
    pend_t        expq [$];
    int           m_state = 0;     // 0 idle, 1 run, 2 drain, 3 done
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    int           cyc     = 0;
    bit           ready_b = 1'b0;
    bit           start_b = 1'b0;
    bit           flush_b = 1'b0;
    logic [15:0]  pop_log [$];
    int           pop_cyc [$];
    int           acc_lane [$];
    logic [31:0]  acc_word [$];
    int           dut_acc   = 0;
    int           done_seen = 0;
    int           done_cyc  = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle. Drive inputs, sample and check at the falling edge,
    // advance the reference model, then apply the FIFO pops after the rising edge.
    task automatic cycle();
        int          pend;
        int          grant;
        int          nxt;
        bit          anyne;
        bit          exp_valid;
        bit          acc;
        logic [15:0] one;
        logic [15:0] exp_rd;
        for (int k = 0; k < 16; k++) fifo_empty[k] = (lq[k].size() == 0);
        out_ready = ready_b;
        start     = start_b;
        flush     = flush_b;
        @(negedge clk);
        check_eq("busy", {31'd0, busy}, {31'd0, (m_state == 1) || (m_state == 2)});
        check_eq("done", {31'd0, done}, {31'd0, (m_state == 3)});
        exp_valid = (expq.size() > 0) && (expq[0].cyc <= cyc - 2);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check_eq("out_a_idx", {16'd0, out_a_idx}, {16'd0, expq[0].word[31:16]});
            check_eq("out_b_idx", {16'd0, out_b_idx}, {16'd0, expq[0].word[15:0]});
            check_eq("out_lane", {28'd0, out_lane}, 32'(expq[0].lane));
        end
        check_eq("match_count", {16'd0, match_count}, 32'(m_cnt));
        if (out_valid && out_ready) begin
            dut_acc++;
            acc_lane.push_back(int'(out_lane));
            acc_word.push_back({out_a_idx, out_b_idx});
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
        acc   = exp_valid && ready_b;
        pend  = expq.size() - (acc ? 1 : 0);
        anyne = 1'b0;
        for (int k = 0; k < 16; k++) if (lq[k].size() > 0) anyne = 1'b1;
        grant = -1;
        if (((m_state == 1) || (m_state == 2)) && anyne && (pend < 2)) begin
            for (int i = 0; i < 16; i++) begin
                if ((grant < 0) && (lq[(m_ptr + i) % 16].size() > 0)) grant = (m_ptr + i) % 16;
            end
        end
        one    = 16'd1;
        exp_rd = (grant >= 0) ? (one << grant) : 16'd0;
        check_eq("fifo_rd", {16'd0, fifo_rd}, {16'd0, exp_rd});
        if (fifo_rd != 16'd0) begin
            pop_log.push_back(fifo_rd);
            pop_cyc.push_back(cyc);
        end
        nxt = m_state;
        case (m_state)
            0: if (start_b) begin nxt = 1; m_cnt = 0; end
            1: if (flush_b) nxt = 2;
            2: if (!anyne && (expq.size() == 0)) nxt = 3;
            default: nxt = 0;
        endcase
        if (acc) begin
            void'(expq.pop_front());
`ifdef PIC_MATCH_COUNT_EN
            if (m_cnt < 65535) m_cnt++;
`endif
        end
        if (grant >= 0) begin
            expq.push_back('{grant, lq[grant][0], cyc});
            m_ptr = (grant + 1) % 16;
        end
        m_state = nxt;
        @(posedge clk);
        #1;
        if (grant >= 0) fifo_data[grant] = lq[grant].pop_front();
        cyc++;
        start_b = 1'b0;
        flush_b = 1'b0;
    endtask

    // Asynchronous reset: the outputs must clear at once. Release happens
    // away from the clock edge.
    task automatic do_reset(input bit clear_lanes);
        reset = 1'b0;
        #2;
        check_eq("rst_fifo_rd", {16'd0, fifo_rd}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        if (clear_lanes) for (int k = 0; k < 16; k++) lq[k].delete();
        for (int k = 0; k < 16; k++) fifo_empty[k] = (lq[k].size() == 0);
        repeat (2) @(posedge clk);
        check_eq("rst_out_data", {out_a_idx, out_b_idx}, 32'd0);
        check_eq("rst_out_lane", {28'd0, out_lane}, 32'd0);
        check_eq("rst_match_count", {16'd0, match_count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_state = 0; m_ptr = 0; m_cnt = 0;
        expq.delete();
        start_b = 1'b0; flush_b = 1'b0;
    endtask

    task automatic run_until_done(input int bound);
        int k = 0;
        while ((m_state != 3) && (k < bound)) begin
            cycle();
            k++;
        end
        check_eq("drain_timeout", {31'd0, (k < bound)}, 32'd1);
        if (m_state == 3) cycle();
    endtask

    task automatic clear_logs();
        pop_log.delete(); pop_cyc.delete();
        acc_lane.delete(); acc_word.delete();
        dut_acc = 0; done_seen = 0; done_cyc = -1;
    endtask

    initial begin
        int s;
        int fc;
        #3;
        do_reset(1'b1);

        // Single word on lane 5: pop in the first RUN cycle, pair 2 cycles later.
        clear_logs();
        lq[5].push_back(32'h0003_0007);
        ready_b = 1'b1; start_b = 1'b1; s = cyc;
        cycle();
        repeat (6) cycle();
        check_eq("t1_pops", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) begin
            check_eq("t1_rd", {16'd0, pop_log[0]}, 32'h0000_0020);
            check_eq("t1_pop_cyc", 32'(pop_cyc[0]), 32'(s + 1));
        end
        check_eq("t1_accepts", 32'(dut_acc), 32'd1);
        if (acc_word.size() > 0) begin
            check_eq("t1_word", acc_word[0], 32'h0003_0007);
            check_eq("t1_lane", 32'(acc_lane[0]), 32'd5);
        end
        flush_b = 1'b1;
        run_until_done(50);

        // Lanes 0, 3, 15, then a wrap back to lane 0.
        do_reset(1'b1);
        clear_logs();
        lq[0].push_back($urandom); lq[3].push_back($urandom); lq[15].push_back($urandom);
        ready_b = 1'b1; start_b = 1'b1;
        repeat (9) cycle();
        check_eq("t2_pops", 32'(pop_log.size()), 32'd3);
        if (pop_log.size() == 3) begin
            check_eq("t2_pop0", {16'd0, pop_log[0]}, 32'h0001);
            check_eq("t2_pop1", {16'd0, pop_log[1]}, 32'h0008);
            check_eq("t2_pop2", {16'd0, pop_log[2]}, 32'h8000);
        end
        if (acc_lane.size() == 3) begin
            check_eq("t2_lane_order", 32'(acc_lane[0] * 256 + acc_lane[1] * 16 + acc_lane[2]), 32'h03F);
        end else begin
            check_eq("t2_accepts", 32'(acc_lane.size()), 32'd3);
        end
        clear_logs();
        lq[1].push_back($urandom); lq[0].push_back($urandom);
        repeat (5) cycle();
        if (pop_log.size() > 0) check_eq("t2_wrap_pop", {16'd0, pop_log[0]}, 32'h0001);
        else check_eq("t2_wrap_pops", 32'(pop_log.size()), 32'd2);
        flush_b = 1'b1;
        run_until_done(50);

        // All lanes hold two words with a toggling consumer.
        do_reset(1'b1);
        clear_logs();
        for (int k = 0; k < 16; k++) begin
            lq[k].push_back($urandom);
            lq[k].push_back($urandom);
        end
        start_b = 1'b1; ready_b = 1'b0;
        cycle();
        for (int n = 0; n < 300; n++) begin
            bit anyl = 1'b0;
            for (int k = 0; k < 16; k++) if (lq[k].size() > 0) anyl = 1'b1;
            if (!anyl && (expq.size() == 0)) break;
            ready_b = ~ready_b;
            cycle();
        end
        check_eq("t3_delivered", 32'(dut_acc), 32'd32);
        ready_b = 1'b1; flush_b = 1'b1;
        run_until_done(50);

        // Flush with four pairs pending.
        do_reset(1'b1);
        lq[1].push_back($urandom); lq[2].push_back($urandom);
        lq[6].push_back($urandom); lq[9].push_back($urandom);
        ready_b = 1'b0; start_b = 1'b1;
        repeat (5) cycle();
        flush_b = 1'b1;
        cycle();
        clear_logs();
        ready_b = 1'b1;
        run_until_done(50);
        cycle();
        check_eq("t4_done_pulses", 32'(done_seen), 32'd1);
        check_eq("t4_delivered", 32'(dut_acc), 32'd4);
        check_eq("t4_busy_low", {31'd0, busy}, 32'd0);
`ifdef PIC_MATCH_COUNT_EN
        check_eq("t4_match_count", {16'd0, match_count}, 32'd4);
`else
        check_eq("t4_match_count", {16'd0, match_count}, 32'd0);
`endif

        // Reset with a pair in flight and one on the output.
        do_reset(1'b1);
        lq[2].push_back($urandom); lq[4].push_back($urandom); lq[7].push_back($urandom);
        ready_b = 1'b0; start_b = 1'b1;
        repeat (3) cycle();
        check_eq("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        do_reset(1'b0);
        ready_b = 1'b1;
        clear_logs();
        repeat (4) cycle();
        check_eq("t5_no_pop_idle", 32'(pop_log.size()), 32'd0);
        start_b = 1'b1;
        repeat (6) cycle();
        flush_b = 1'b1;
        run_until_done(50);

        // Stray pulses, then flush coinciding with the exit condition.
        do_reset(1'b1);
        clear_logs();
        flush_b = 1'b1;
        repeat (3) cycle();
        check_eq("t6_idle_busy", {31'd0, busy}, 32'd0);
        start_b = 1'b1;
        cycle();
        start_b = 1'b1;
        cycle();
        lq[11].push_back($urandom);
        repeat (5) cycle();
        check_eq("t6_run_busy", {31'd0, busy}, 32'd1);
        check_eq("t6_no_done", 32'(done_seen), 32'd0);
        flush_b = 1'b1; fc = cyc;
        run_until_done(10);
        check_eq("t6_done_delay", 32'(done_cyc - fc), 32'd2);

        // Randomised runs.
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b1);
            for (int k = 0; k < 16; k++) begin
                int nw = $urandom_range(0, 3);
                for (int w = 0; w < nw; w++) lq[k].push_back($urandom);
            end
            start_b = 1'b1;
            for (int n = 0; n < 20; n++) begin
                ready_b = ($urandom % 4) != 0;
                if ($urandom % 3 == 0) lq[$urandom % 16].push_back($urandom);
                cycle();
            end
            flush_b = 1'b1;
            for (int n = 0; n < 400 && m_state != 3; n++) begin
                ready_b = ($urandom % 4) != 0;
                cycle();
            end
            ready_b = 1'b1;
            run_until_done(50);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pic_match_collector.md
Name: pic_match_collector

Overview:
- Downstream of the 4x4 parallel index comparison array.
- Drains the 16 per-PIC match FIFOs with a round-robin arbiter and serialises matched index pairs into one valid/ready stream for the multiply-accumulate stage.
- Tracks in-flight reads, buffers up to two pairs, and signals completion once a flush has been requested and every FIFO is empty.

Parameters:
- NUM_LANES, 16, number of PIC FIFOs drained; lane k = A(k/4) x B(k%4).
- DATA_W, 32, FIFO word width: [31:16] A-side index, [15:0] B-side index.
- LANE_W, 4, width of lane id, log2(NUM_LANES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse, begins collection (honoured in IDLE only).
- flush  in  1  one-cycle pulse, upstream has finished writing (honoured in RUN only).
- fifo_data  in  16x32  read data of each PIC FIFO, valid the cycle after its fifo_rd.
- fifo_empty  in  16  per-FIFO empty flag.
- fifo_rd  out  16  one-hot (or zero) pop strobe.
- out_valid  out  1  out_a_idx/out_b_idx/out_lane hold a pair.
- out_ready  in  1  consumer accepts the pair when out_valid && out_ready.
- out_a_idx  out  16  A index of the pair.
- out_b_idx  out  16  B index of the pair.
- out_lane  out  4  source lane: [3:2] A lane, [1:0] B lane.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse.
- match_count  out  16  accepted-pair count (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - State IDLE; fifo_rd=0, out_valid=0, out_* data=0.
  - busy=0, done=0, match_count=0.
  - RR pointer=0, buffer and in-flight flag cleared.
  - Reset mid-operation drops all buffered and in-flight pairs; no pop is issued in the first cycle after release.
- FSM:
  - IDLE: start -> RUN. flush is ignored.
  - RUN: flush -> DRAIN. start is ignored. Pops continue.
  - DRAIN: pops continue. Exit to DONE when all fifo_empty=1, nothing is in flight, and the buffer is empty, all in the same cycle.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - flush and the exit condition in the same RUN cycle: still go RUN -> DRAIN -> DONE; done fires no earlier than 2 cycles after flush.
- Pop rule (RUN and DRAIN only):
  - Issue a pop in cycle t only if buffer occupancy + in-flight < 2 and some lane is non-empty.
  - Grant = lowest lane index >= pointer with fifo_empty=0, wrapping 15 -> 0.
  - After a grant, pointer = (grant+1) mod 16. With no grant, pointer holds.
  - At most one fifo_rd bit is high per cycle; never pop a lane whose fifo_empty=1 in that cycle.
- Capture:
  - Data of the lane popped at t is captured at the end of cycle t+1 into the 2-entry FIFO-ordered buffer.
  - out_valid rises in cycle t+2 at the earliest; latency pop-to-valid is 2 cycles.
- Output handshake:
  - While out_valid=1 && out_ready=0, out_a_idx/out_b_idx/out_lane hold stable.
  - Capture and accept in the same cycle: occupancy is unchanged, and pair order is preserved.
  - Sustained throughput is 1 pair/cycle with out_ready held high.
- Field split: out_a_idx=word[31:16], out_b_idx=word[15:0], out_lane=granted lane.
- busy = state in {RUN, DRAIN}.

Optional Feature:
- Macro: PIC_MATCH_COUNT_EN.
- Defined:
  - match_count increments on every accepted pair (out_valid && out_ready).
  - Saturates at 0xFFFF.
  - Cleared on reset and on the IDLE->RUN transition; holds its value in DONE and IDLE.
- Undefined: match_count tied to 0; no counter logic.

Test Plan:
- Lane 5 only holds 0x0003_0007, start, out_ready=1 -> fifo_rd=0x0020 in cycle t; out_valid at t+2 with a=3, b=7, lane=5.
- Lanes 0, 3, 15 each hold one word, pointer=0 -> pops in order 0, 3, 15; pointer ends at 0 (wrap); three pairs emitted in that order.
- All 16 lanes hold 2 words, out_ready toggling 1/0 -> data stable while stalled, never >2 pairs buffered, 32 pairs delivered with no loss, duplication or fifo_rd on an empty lane.
- flush issued while 4 pairs are pending -> DRAIN, all 4 delivered, then done pulses once for 1 cycle and busy falls; match_count=4 with PIC_MATCH_COUNT_EN.
- reset asserted with a pair in flight and out_valid=1 -> out_valid=0 and fifo_rd=0 immediately; after release, IDLE and start required.
- start pulsed in RUN and flush pulsed in IDLE -> no state change, no done.
